// File: rtl/guitar_input_pkg.sv
// Shared types and defaults for the guitar input conditioner.
// Timing defaults assume the 100 MHz system clock.
package guitar_input_pkg;

  localparam int NUM_FRETS_DEFAULT       = 4;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

  typedef enum logic {
    S_IDLE,
    S_PENDING
  } strum_state_t;

  // both_edges selects whether a release also counts as a strum
  function automatic logic strum_edge(input logic level, input logic level_prev,
                                      input logic both_edges);
    if (both_edges) begin
      return level ^ level_prev;
    end
    return level & ~level_prev;
  endfunction

endpackage

// File: rtl/guitar_input_conditioner_debouncer.sv
// input_debouncer: 2-flop synchroniser followed by a consecutive-sample debouncer.
// The level flips only after DEBOUNCE_CYCLES differing samples in a row (DEBOUNCE_CYCLES >= 2).
module input_debouncer
  import guitar_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // the run of differing samples is long enough: accept the new level
        stable_q <= sync_q2;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level = stable_q;

endmodule

// File: rtl/guitar_input_conditioner.sv
// Debounces fret and strum inputs and latches strum events with a fret snapshot until acked.
// Define STRUM_BOTH_EDGES_EN to treat strum releases as events as well as presses.
//
// state     | meaning
// S_IDLE    | no strum event waiting for the processor
// S_PENDING | event latched in strum_frets/strum_count, waiting for strum_ack
module guitar_input_conditioner
  import guitar_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int NUM_FRETS       = NUM_FRETS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_FRETS-1:0] fret_raw,
  input  logic                 strum_raw,
  input  logic                 strum_ack,
  output logic [NUM_FRETS-1:0] fret_out,
  output logic                 strum_level,
  output logic                 strum_valid,
  output logic [NUM_FRETS-1:0] strum_frets,
  output logic                 strum_overrun,
  output logic [7:0]           strum_count
);

`ifdef STRUM_BOTH_EDGES_EN
  localparam logic BOTH_EDGES = 1'b1;
`else
  localparam logic BOTH_EDGES = 1'b0;
`endif

  for (genvar i = 0; i < NUM_FRETS; i++) begin : g_fret
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_fret_db (
      .clk   (clk),
      .reset (reset),
      .raw   (fret_raw[i]),
      .level (fret_out[i])
    );
  end

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_strum_db (
    .clk   (clk),
    .reset (reset),
    .raw   (strum_raw),
    .level (strum_level)
  );

  logic strum_level_q;
  logic strum_event;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strum_level_q <= 1'b0;
    end else begin
      strum_level_q <= strum_level;
    end
  end

  assign strum_event = strum_edge(strum_level, strum_level_q, BOTH_EDGES);

  strum_state_t         state_q;
  strum_state_t         state_d;
  logic [NUM_FRETS-1:0] frets_q;
  logic [NUM_FRETS-1:0] frets_d;
  logic                 overrun_q;
  logic                 overrun_d;
  logic [7:0]           count_q;
  logic [7:0]           count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      frets_q   <= '0;
      overrun_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      frets_q   <= frets_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    frets_d   = frets_q;
    overrun_d = overrun_q;
    count_d   = count_q;
    case (state_q)
      S_IDLE: begin
        if (strum_event) begin
          state_d = S_PENDING;
          frets_d = fret_out;
          count_d = count_q + 8'd1;
        end
      end
      S_PENDING: begin
        // a fresh strum replaces the one being acked; without an ack the oldest is kept
        if (strum_event && strum_ack) begin
          frets_d = fret_out;
          count_d = count_q + 8'd1;
        end else if (strum_event) begin
          overrun_d = 1'b1;
        end else if (strum_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign strum_valid   = (state_q == S_PENDING);
  assign strum_frets   = frets_q;
  assign strum_overrun = overrun_q;
  assign strum_count   = count_q;

endmodule

// File: tb/tb_guitar_input_conditioner.sv
// Self-checking bench for guitar_input_conditioner with DEBOUNCE_CYCLES=4.
// Reference model judges debounce by a sliding window of synchronised samples.
module tb_guitar_input_conditioner;

  localparam int D  = 4;
  localparam int NF = 4;
`ifdef STRUM_BOTH_EDGES_EN
  localparam logic BOTH = 1'b1;
`else
  localparam logic BOTH = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NF-1:0] fret_raw = '0;
  logic          strum_raw = 1'b0;
  logic          strum_ack = 1'b0;
  logic [NF-1:0] fret_out;
  logic          strum_level;
  logic          strum_valid;
  logic [NF-1:0] strum_frets;
  logic          strum_overrun;
  logic [7:0]    strum_count;

  int n_vec = 0;
  int n_err = 0;

  guitar_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .NUM_FRETS(NF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fret_raw      (fret_raw),
    .strum_raw     (strum_raw),
    .strum_ack     (strum_ack),
    .fret_out      (fret_out),
    .strum_level   (strum_level),
    .strum_valid   (strum_valid),
    .strum_frets   (strum_frets),
    .strum_overrun (strum_overrun),
    .strum_count   (strum_count)
  );

  always #5 clk = ~clk;

  // reference model: raw samples per edge, sync output lags raw by two edges
  logic [NF:0]   hist[$];
  logic [NF-1:0] m_fret;
  logic          m_level, m_prev, m_valid, m_ovr, m_ev, m_cur, m_flip;
  logic [NF-1:0] m_frets;
  logic [7:0]    m_cnt;
  int            m_n;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
      for (int i = 0; i < D + 2; i++) hist.push_back('0);
      m_fret = '0; m_level = 0; m_prev = 0; m_valid = 0;
      m_frets = '0; m_ovr = 0; m_cnt = 8'd0;
    end else begin
      m_ev = BOTH ? (m_level != m_prev) : (m_level && !m_prev);
      if (!m_valid) begin
        if (m_ev) begin m_valid = 1; m_frets = m_fret; m_cnt = m_cnt + 8'd1; end
      end else if (m_ev && strum_ack) begin
        m_frets = m_fret; m_cnt = m_cnt + 8'd1;
      end else if (m_ev) begin
        m_ovr = 1;
      end else if (strum_ack) begin
        m_valid = 0;
      end
      m_prev = m_level;
      hist.push_back({strum_raw, fret_raw});
      if (hist.size() > D + 3) hist.delete(0);
      m_n = hist.size();
      // a level flips once the last D synchronised samples all disagree with it
      for (int b = 0; b <= NF; b++) begin
        m_cur  = (b == NF) ? m_level : m_fret[b];
        m_flip = 1;
        for (int j = 0; j < D; j++) if (hist[m_n-3-j][b] == m_cur) m_flip = 0;
        if (m_flip) begin
          if (b == NF) m_level = ~m_level;
          else m_fret[b] = ~m_fret[b];
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_pending();
    if (m_valid) begin
      strum_ack = 1'b1;
      @(negedge clk);
      strum_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [NF-1:0] exp;
    @(negedge clk);
    fret_raw = '1; strum_raw = 1'b1; strum_ack = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (fret_out !== '0) begin n_err++; $display("FAIL reset_fret_out got %b want 0", fret_out); end
    n_vec++; if (strum_level !== 1'b0) begin n_err++; $display("FAIL reset_strum_level got %b want 0", strum_level); end
    n_vec++; if (strum_valid !== 1'b0) begin n_err++; $display("FAIL reset_strum_valid got %b want 0", strum_valid); end
    n_vec++; if (strum_frets !== '0) begin n_err++; $display("FAIL reset_strum_frets got %b want 0", strum_frets); end
    n_vec++; if (strum_overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %b want 0", strum_overrun); end
    n_vec++; if (strum_count !== 8'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", strum_count); end
    fret_raw = 4'b0101; strum_raw = 1'b0; reset = 1'b0;
    for (int k = 0; k <= D + 1; k++) begin
      @(negedge clk);
      exp = (k >= D + 1) ? 4'b0101 : 4'b0000;
      n_vec++; if (fret_out !== exp) begin n_err++; $display("FAIL release_latency edge %0d got %b want %b", k, fret_out, exp); end
    end
    fret_raw = 4'b1010;
    settle(3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k <= D + 1; k++) begin
      @(negedge clk);
      exp = (k >= D + 1) ? 4'b1010 : 4'b0000;
      n_vec++; if (fret_out !== exp) begin n_err++; $display("FAIL mid_debounce_reset edge %0d got %b want %b", k, fret_out, exp); end
    end
  endtask

  task automatic test_glitch();
    int k;
    @(negedge clk);
    fret_raw = '0; strum_raw = 1'b0;
    settle(8);
    for (int i = 0; i < 20; i++) begin
      fret_raw[0] = ((i / 2) % 2 == 0);
      @(negedge clk);
      n_vec++; if (fret_out[0] !== 1'b0) begin n_err++; $display("FAIL glitch_reject cycle %0d got %b want 0", i, fret_out[0]); end
    end
    fret_raw[0] = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (fret_out[0] === 1'b1) break;
    end
    n_vec++; if (k != D + 1) begin n_err++; $display("FAIL glitch_hold_latency got %0d want %0d", k, D + 1); end
  endtask

  task automatic test_strum_ack();
    int k;
    fret_raw = 4'b1010; strum_raw = 1'b0; strum_ack = 1'b0;
    do_reset();
    settle(8);
    strum_raw = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (strum_valid === 1'b1) break;
    end
    n_vec++; if (k != D + 2) begin n_err++; $display("FAIL strum_latency got %0d want %0d", k, D + 2); end
    n_vec++; if (strum_frets !== 4'b1010) begin n_err++; $display("FAIL strum_frets got %b want 1010", strum_frets); end
    n_vec++; if (strum_count !== 8'd1) begin n_err++; $display("FAIL strum_count got %0d want 1", strum_count); end
    strum_ack = 1'b1;
    @(negedge clk);
    strum_ack = 1'b0;
    n_vec++; if (strum_valid !== 1'b0) begin n_err++; $display("FAIL ack_clears got %b want 0", strum_valid); end
    strum_raw = 1'b0;
    settle(8);
    clear_pending();
  endtask

  task automatic test_overrun();
    fret_raw = 4'b1010; strum_raw = 1'b0; strum_ack = 1'b0;
    do_reset();
    settle(8);
    strum_raw = 1'b1; settle(8);
    strum_raw = 1'b0; settle(8);
    fret_raw = 4'b0001; settle(8);
    strum_raw = 1'b1; settle(8);
    n_vec++; if (strum_frets !== 4'b1010) begin n_err++; $display("FAIL overrun_frets got %b want 1010", strum_frets); end
    n_vec++; if (strum_overrun !== 1'b1) begin n_err++; $display("FAIL overrun_flag got %b want 1", strum_overrun); end
    n_vec++; if (strum_count !== 8'd1) begin n_err++; $display("FAIL overrun_count got %0d want 1", strum_count); end
    n_vec++; if (strum_valid !== 1'b1) begin n_err++; $display("FAIL overrun_valid got %b want 1", strum_valid); end
  endtask

  task automatic test_ack_collision_and_wrap();
    fret_raw = 4'b1010; strum_raw = 1'b0; strum_ack = 1'b0;
    do_reset();
    settle(8);
    strum_raw = 1'b1; settle(8);
    strum_raw = 1'b0; settle(8);
    fret_raw = 4'b0011; settle(8);
    strum_raw = 1'b1;
    settle(D + 2);
    strum_ack = 1'b1;
    @(negedge clk);
    strum_ack = 1'b0;
    n_vec++; if (strum_valid !== 1'b1) begin n_err++; $display("FAIL collide_valid got %b want 1", strum_valid); end
    n_vec++; if (strum_frets !== 4'b0011) begin n_err++; $display("FAIL collide_frets got %b want 0011", strum_frets); end
    n_vec++; if (strum_count !== 8'd2) begin n_err++; $display("FAIL collide_count got %0d want 2", strum_count); end
    clear_pending();
    for (int it = 0; it < 1200 && m_cnt != 8'd255; it++) begin
      strum_raw = ~strum_raw;
      settle(8);
      clear_pending();
    end
    n_vec++; if (strum_count !== 8'd255) begin n_err++; $display("FAIL wrap_reach got %0d want 255", strum_count); end
    for (int it = 0; it < 4 && m_cnt == 8'd255; it++) begin
      strum_raw = ~strum_raw;
      settle(8);
    end
    n_vec++; if (strum_count !== 8'd0) begin n_err++; $display("FAIL wrap_zero got %0d want 0", strum_count); end
    n_vec++; if (strum_valid !== 1'b1) begin n_err++; $display("FAIL wrap_valid got %b want 1", strum_valid); end
  endtask

  task automatic test_release();
    fret_raw = 4'b0110; strum_raw = 1'b0; strum_ack = 1'b0;
    do_reset();
    settle(8);
    strum_raw = 1'b1; settle(8);
    strum_raw = 1'b0; settle(8);
    n_vec++; if (strum_overrun !== BOTH) begin n_err++; $display("FAIL release_overrun got %b want %b", strum_overrun, BOTH); end
    n_vec++; if (strum_count !== 8'd1) begin n_err++; $display("FAIL release_count got %0d want 1", strum_count); end
    n_vec++; if (strum_frets !== 4'b0110) begin n_err++; $display("FAIL release_frets got %b want 0110", strum_frets); end
  endtask

  task automatic test_random();
    strum_ack = 1'b0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      n_vec++; if (fret_out !== m_fret) begin n_err++; $display("FAIL rnd_fret_out cyc %0d got %b want %b", c, fret_out, m_fret); end
      n_vec++; if (strum_level !== m_level) begin n_err++; $display("FAIL rnd_strum_level cyc %0d got %b want %b", c, strum_level, m_level); end
      n_vec++; if (strum_valid !== m_valid) begin n_err++; $display("FAIL rnd_strum_valid cyc %0d got %b want %b", c, strum_valid, m_valid); end
      n_vec++; if (strum_frets !== m_frets) begin n_err++; $display("FAIL rnd_strum_frets cyc %0d got %b want %b", c, strum_frets, m_frets); end
      n_vec++; if (strum_overrun !== m_ovr) begin n_err++; $display("FAIL rnd_overrun cyc %0d got %b want %b", c, strum_overrun, m_ovr); end
      n_vec++; if (strum_count !== m_cnt) begin n_err++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, strum_count, m_cnt); end
      reset = (c == 700);
      if ($urandom_range(0, 5) == 0) fret_raw = NF'($urandom);
      if ($urandom_range(0, 6) == 0) strum_raw = ~strum_raw;
      strum_ack = ($urandom_range(0, 3) == 0);
    end
    reset = 1'b0;
    strum_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_strum_ack();
    test_overrun();
    test_ack_collision_and_wrap();
    test_release();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/guitar_input_conditioner.md
# guitar_input_conditioner

Conditions the raw guitar-controller inputs (four fret buttons and the strum bar) before they reach the processor wrapper and game logic. Each raw input is synchronised and debounced on the 100 MHz system clock. Strum edges become latched strum events that carry a snapshot of the fret chord and are held until acknowledged, so the 1 MHz processor clock domain cannot miss them. The block sits between the board pins and the wrapper's `buttons`/`strum` inputs.

## Interface
- `DEBOUNCE_CYCLES`, 1000000, consecutive stable samples required to accept a level change (10 ms at 100 MHz); must be ≥ 2
- `NUM_FRETS`, 4, number of fret buttons
- `clk`  in  1  100 MHz system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `fret_raw`  in  NUM_FRETS  raw fret buttons, active-high, asynchronous to clk
- `strum_raw`  in  1  raw strum bar, active-high, asynchronous
- `strum_ack`  in  1  clk-domain acknowledge of the pending strum event
- `fret_out`  out  NUM_FRETS  debounced fret levels
- `strum_level`  out  1  debounced strum level
- `strum_valid`  out  1  strum event pending
- `strum_frets`  out  NUM_FRETS  `fret_out` captured at the event
- `strum_overrun`  out  1  sticky: event lost while one was pending
- `strum_count`  out  8  accepted events, wraps 255→0

## Operation
- Per input: a 2-flop synchroniser feeds the debouncer. The debouncer holds a `stable` bit and a counter of width `$clog2(DEBOUNCE_CYCLES)`.
  - If the synchronised value equals `stable`, the counter clears.
  - Otherwise the counter increments. When it is at `DEBOUNCE_CYCLES-1` and the value still differs, `stable` takes the new value and the counter clears.
  - A single agreeing sample restarts the count.
- Strum event source: a rising edge of `strum_level`. With `STRUM_BOTH_EDGES_EN` defined, falling edges also count (see Configuration).
- Strum FSM states:
  - S_IDLE, `strum_valid`=0. On an event: go to S_PENDING, capture `strum_frets`←`fret_out` as of the same cycle, increment `strum_count`.
  - S_PENDING, `strum_valid`=1.
    - `strum_ack`=1, no event: go to S_IDLE.
    - Event and `strum_ack` in the same cycle: the new event wins. Stay in S_PENDING, recapture `strum_frets`, increment the count.
    - Event without `strum_ack`: set `strum_overrun`. `strum_frets` and `strum_count` are unchanged (the oldest event is kept).
  - `strum_ack` in S_IDLE is ignored.
- `strum_overrun` clears only on reset.

## Timing
- Reset: synchronisers, `stable` bits, counters, `fret_out`, `strum_level`, `strum_valid`, `strum_frets`, `strum_overrun` and `strum_count` are all 0. FSM is S_IDLE.
- Reset mid-debounce discards the partial count. Reset with inputs held high: the outputs rise again after full debounce latency.
- Debounce latency: a raw change first captured at edge 0 appears on `fret_out`/`strum_level` after edge `DEBOUNCE_CYCLES+1`.
- Strum path: `strum_valid`, `strum_frets` and `strum_count` update at the edge after `strum_level` changes, giving total latency `DEBOUNCE_CYCLES+2`.
- Ack: `strum_valid` falls at the edge that samples `strum_valid & strum_ack`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `STRUM_BOTH_EDGES_EN`
  - Defined: rising and falling edges of `strum_level` each generate an event. This models a strum bar that is flicked up and down.
  - Undefined: rising edge only; the release generates nothing.

## Structure
- Package `guitar_input_pkg` holds:
  - `NUM_FRETS_DEFAULT` = 4
  - `DEBOUNCE_CYCLES_DEFAULT` = 1000000
  - `typedef enum logic {S_IDLE, S_PENDING} strum_state_t`
- Sub-module `input_debouncer` (synchroniser + counter + stable bit, parameter `DEBOUNCE_CYCLES`). It is instantiated NUM_FRETS+1 times; the top level holds edge detection and the FSM.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset with all raw inputs at 1 → every output 0; release reset, hold `fret_raw`=4'b0101 → `fret_out`=4'b0101 exactly 5 edges after first capture, never earlier.
- `fret_raw[0]` toggling every 2 cycles for 20 cycles → `fret_out[0]` stays 0; then held at 1 → rises after full latency.
- `fret_raw`=4'b1010 stable, then strum press → `strum_valid`=1, `strum_frets`=4'b1010, `strum_count`=1; one-cycle `strum_ack` → `strum_valid`=0 the next cycle.
- Two strum presses with no ack, frets 1010 then 0001 → `strum_frets` stays 1010, `strum_overrun`=1, `strum_count`=1.
- New event on the same cycle as `strum_ack` (frets 0011) → `strum_valid` stays 1, `strum_frets`=4'b0011, `strum_count` increments; with the count at 255, the next accepted event → 0.
- Strum press then release, no ack between → with `STRUM_BOTH_EDGES_EN`: `strum_overrun`=1; without it: `strum_overrun`=0 and `strum_count`=1.
